// File: rtl/axis_video_out.sv
// rtl/axis_video_out.sv - AXI4-Stream to video output stage: pixel FIFO, timing generator, SOF lock
module axis_video_out #(
    parameter int   DATA_BITS  = 8,
    parameter int   PPC        = 1,
    parameter int   ADDR_BITS  = 6,
    parameter int   H_DISP     = 40,
    parameter int   H_FRONT    = 5,
    parameter int   H_PULSE    = 10,
    parameter int   H_BACK     = 5,
    parameter int   V_DISP     = 30,
    parameter int   V_FRONT    = 2,
    parameter int   V_PULSE    = 4,
    parameter int   V_BACK     = 2,
    parameter logic H_POL      = 1'b0,
    parameter logic V_POL      = 1'b1,
    parameter int   FILL_VALUE = 0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         enable,
    input  logic [DATA_BITS*PPC-1:0]     s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tuser,
    output logic                         vid_hsync,
    output logic                         vid_vsync,
    output logic                         vid_active_video,
    output logic [DATA_BITS*PPC-1:0]     vid_data,
    output logic                         locked,
    output logic                         underflow,
    output logic                         sync_err,
    output logic [15:0]                  underflow_count,
    output logic [ADDR_BITS:0]           fifo_level
);
    localparam int W       = DATA_BITS * PPC;
    localparam int H_TOTAL = H_DISP + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_DISP + V_FRONT + V_PULSE + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DEPTH   = 1 << ADDR_BITS;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_DISP);
    localparam logic [HW-1:0] H_EOL    = HW'(H_DISP - 1);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_DISP + H_FRONT);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_DISP + H_FRONT + H_PULSE - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_DISP);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_DISP + V_FRONT);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_DISP + V_FRONT + V_PULSE - 1);

    localparam logic [DATA_BITS-1:0] FILL_PIX  = DATA_BITS'(FILL_VALUE);
    localparam logic [W-1:0]         FILL_WORD = {PPC{FILL_PIX}};

    typedef enum logic [1:0] {SEEK, ARMED, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [HW-1:0]        h_cnt_q;
    logic [VW-1:0]        v_cnt_q;
    logic [ADDR_BITS:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W+1:0]         mem [DEPTH];
    logic [W+1:0]         head;
    logic                 hsync_q, vsync_q, active_q;
    logic [W-1:0]         vid_data_q, vid_data_d;
    logic                 underflow_q, underflow_d, sync_err_q, sync_err_d;
    logic [15:0]          count_q;
    logic                 act, hs_on, vs_on, frame_start, line_end;
    logic                 empty, full, wr_en, pop, flush, tready;
    logic [ADDR_BITS:0]   level;

    assign act         = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_on       = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    assign vs_on       = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
    assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign line_end    = (h_cnt_q == H_EOL);

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = level[ADDR_BITS];
    assign head  = mem[rd_ptr_q[ADDR_BITS-1:0]];

    always_comb begin
        state_d     = state_q;
        tready      = 1'b0;
        wr_en       = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        underflow_d = 1'b0;
        sync_err_d  = 1'b0;
        vid_data_d  = act ? FILL_WORD : '0;
        case (state_q)
            SEEK: begin
                // Non-SOF beats are accepted and dropped; only the SOF beat is stored.
                tready = 1'b1;
                flush  = 1'b1;
                wr_en  = s_axis_tvalid && s_axis_tuser;
                if (wr_en) state_d = ARMED;
            end
            ARMED: begin
                tready = !full;
                wr_en  = s_axis_tvalid && !full;
                if (act && frame_start) begin
                    pop        = 1'b1;
                    vid_data_d = head[W-1:0];
                    state_d    = LOCKED;
                end
            end
            LOCKED: begin
                tready = !full;
                wr_en  = s_axis_tvalid && !full;
                if (act) begin
                    if (empty) begin
                        underflow_d = 1'b1;
                        flush       = 1'b1;
                        state_d     = SEEK;
                    end else begin
                        pop        = 1'b1;
                        vid_data_d = head[W-1:0];
                        if (head[W+1] != frame_start || head[W] != line_end) begin
                            sync_err_d = 1'b1;
                            flush      = 1'b1;
                            state_d    = SEEK;
                        end
                    end
                end
            end
            default: begin
                flush   = 1'b1;
                state_d = SEEK;
            end
        endcase
        if (!enable) begin
            state_d     = SEEK;
            flush       = 1'b1;
            tready      = 1'b0;
            wr_en       = 1'b0;
            pop         = 1'b0;
            underflow_d = 1'b0;
            sync_err_d  = 1'b0;
            vid_data_d  = act ? FILL_WORD : '0;
        end
    end

    // While seeking the FIFO is empty, so the SOF beat always lands in slot 0.
    always_comb begin
        rd_ptr_d = rd_ptr_q + {{ADDR_BITS{1'b0}}, pop};
        wr_ptr_d = wr_ptr_q + {{ADDR_BITS{1'b0}}, wr_en};
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = (state_q == SEEK && wr_en) ? (ADDR_BITS+1)'(1) : '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr_q[ADDR_BITS-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= SEEK;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hsync_q     <= ~H_POL;
            vsync_q     <= ~V_POL;
            active_q    <= 1'b0;
            vid_data_q  <= '0;
            underflow_q <= 1'b0;
            sync_err_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (h_cnt_q == H_LAST) begin
                h_cnt_q <= '0;
                v_cnt_q <= (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_q <= h_cnt_q + HW'(1);
            end
            hsync_q     <= hs_on ? H_POL : ~H_POL;
            vsync_q     <= vs_on ? V_POL : ~V_POL;
            active_q    <= act;
            vid_data_q  <= vid_data_d;
            underflow_q <= underflow_d;
            sync_err_q  <= sync_err_d;
            if (underflow_d && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end
    end

    assign s_axis_tready    = tready;
    assign vid_hsync        = hsync_q;
    assign vid_vsync        = vsync_q;
    assign vid_active_video = active_q;
    assign vid_data         = vid_data_q;
    assign locked           = (state_q == LOCKED);
    assign underflow        = underflow_q;
    assign sync_err         = sync_err_q;
    assign underflow_count  = count_q;
    assign fifo_level       = level;
endmodule

// File: tb/tb_axis_video_out.sv
// tb/tb_axis_video_out.sv - randomized self-checking bench for axis_video_out against a frame-position model
module tb_axis_video_out;
    localparam int FT = 60 * 38;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  tdata = '0;
    logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
    logic        tready;
    logic        hsync, vsync, act_o, locked, underflow, sync_err;
    logic [7:0]  vdata;
    logic [15:0] ucount;
    logic [6:0]  level;

    logic [19:0] tdata2 = '0;
    logic        tvalid2 = 1'b0, tlast2 = 1'b0, tuser2 = 1'b0;
    logic        tready2, hsync2, vsync2, act2, locked2, uf2, se2;
    logic [19:0] vdata2;
    logic [15:0] ucount2;
    logic [6:0]  level2;

    axis_video_out u_dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .vid_hsync(hsync), .vid_vsync(vsync), .vid_active_video(act_o), .vid_data(vdata),
        .locked(locked), .underflow(underflow), .sync_err(sync_err),
        .underflow_count(ucount), .fifo_level(level)
    );

    axis_video_out #(.DATA_BITS(10), .PPC(2), .H_DISP(20)) u_dut2 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .s_axis_tdata(tdata2), .s_axis_tvalid(tvalid2), .s_axis_tready(tready2),
        .s_axis_tlast(tlast2), .s_axis_tuser(tuser2),
        .vid_hsync(hsync2), .vid_vsync(vsync2), .vid_active_video(act2), .vid_data(vdata2),
        .locked(locked2), .underflow(uf2), .sync_err(se2),
        .underflow_count(ucount2), .fifo_level(level2)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk or negedge aresetn)
        if (!aresetn) cyc <= 0;
        else          cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int src_idx = 0;
    bit src_on = 1'b0;
    int src_bad_line = -1;
    int sof_pos = -1;
    int idx2 = 0;

    // Frame source: word index within frame is v*40+h, which is also its payload.
    initial begin
        forever begin
            @(posedge aclk);
            if (tvalid && tready) begin
                if (tuser) sof_pos = cyc;
                src_idx = (src_idx + 1) % 1200;
            end
            #1;
            if (src_on && $urandom_range(7) != 0) begin
                tvalid = 1'b1;
                tdata  = 8'(src_idx);
                tuser  = (src_idx == 0);
                tlast  = (src_idx % 40 == 39) || (src_bad_line >= 0 && src_idx == src_bad_line * 40 + 38);
            end else begin
                tvalid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            if (!aresetn) idx2 = 0;
            else if (tvalid2 && tready2) idx2 = (idx2 + 1) % 600;
            #1;
            tvalid2 = aresetn;
            tdata2  = {10'(2 * idx2 + 1), 10'(2 * idx2)};
            tuser2  = (idx2 == 0);
            tlast2  = (idx2 % 20 == 19);
        end
    end

    int p, h, v;
    bit ehs, evs, eact;
    logic [7:0] edat;

    function automatic void vmodel(input int pos, output bit hs_e, output bit vs_e, output bit act_e,
                                   output int hh, output int vv);
        hh    = pos % 60;
        vv    = (pos / 60) % 38;
        act_e = (hh < 40) && (vv < 30);
        hs_e  = (hh >= 45 && hh < 55) ? 1'b0 : 1'b1;
        vs_e  = (vv >= 32 && vv < 36) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [7:0] pix(input int vv, input int hh);
        return 8'(vv * 40 + hh);
    endfunction

    task automatic test_reset;
        checks++;
        if ({hsync, vsync, act_o, locked, underflow, sync_err} !== 6'b100000) begin
            errors++; $display("FAIL reset_ctrl got %b want 100000", {hsync, vsync, act_o, locked, underflow, sync_err});
        end
        checks++;
        if ({vdata, ucount, level} !== '0) begin
            errors++; $display("FAIL reset_vals got data=%0d count=%0d level=%0d want 0", vdata, ucount, level);
        end
    endtask

    task automatic test_ppc2;
        int lockp = -1;
        int hh, vv;
        logic [19:0] e2;
        for (int i = 0; i < 3 * 1520; i++) begin
            @(negedge aclk);
            p  = cyc - 1;
            hh = p % 40;
            vv = (p / 40) % 38;
            checks++;
            if ({hsync2, vsync2, act2} !== {(hh >= 25 && hh < 35) ? 1'b0 : 1'b1, vv >= 32 && vv < 36, hh < 20 && vv < 30}) begin
                errors++; if (errors < 40) $display("FAIL ppc2_timing p=%0d got %b", p, {hsync2, vsync2, act2});
            end
            if (locked2 && lockp < 0) begin
                lockp = p;
                checks++;
                if (p != 1520) begin errors++; $display("FAIL ppc2_lock_pos got %0d want 1520", p); end
            end
            e2 = (hh < 20 && vv < 30 && locked2) ? {10'(2 * (vv * 20 + hh) + 1), 10'(2 * (vv * 20 + hh))} : 20'd0;
            checks++;
            if (vdata2 !== e2) begin
                errors++; if (errors < 40) $display("FAIL ppc2_data p=%0d got %h want %h", p, vdata2, e2);
            end
        end
        checks++;
        if (lockp < 0) begin errors++; $display("FAIL ppc2_nolock got none want 1520"); end
    endtask

    task automatic test_stream;
        int lockp = -1;
        sof_pos = -1;
        src_idx = 0;
        src_on  = 1'b1;
        for (int i = 0; i < 4 * FT; i++) begin
            @(negedge aclk);
            p = cyc - 1;
            vmodel(p, ehs, evs, eact, h, v);
            checks++;
            if ({hsync, vsync, act_o} !== {ehs, evs, eact}) begin
                errors++; if (errors < 40) $display("FAIL stream_timing p=%0d got %b want %b", p, {hsync, vsync, act_o}, {ehs, evs, eact});
            end
            if (locked && lockp < 0) begin
                lockp = p;
                checks++;
                if (sof_pos < 0 || p != (sof_pos / FT + 1) * FT) begin
                    errors++; $display("FAIL stream_lock_pos got %0d want %0d", p, (sof_pos / FT + 1) * FT);
                end
            end
            edat = (eact && locked) ? pix(v, h) : 8'd0;
            checks++;
            if (vdata !== edat) begin
                errors++; if (errors < 40) $display("FAIL stream_data p=%0d got %0d want %0d", p, vdata, edat);
            end
            checks++;
            if ({underflow, sync_err} !== 2'b00) begin
                errors++; if (errors < 40) $display("FAIL stream_events p=%0d got %b want 00", p, {underflow, sync_err});
            end
        end
        checks++;
        if (lockp < 0) begin errors++; $display("FAIL stream_nolock got none want lock"); end
        src_on = 1'b0;
        enable = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_midframe;
        int lockp = -1;
        sof_pos = -1;
        src_idx = 500;
        enable  = 1'b1;
        src_on  = 1'b1;
        for (int i = 0; i < 3 * FT; i++) begin
            @(negedge aclk);
            p = cyc - 1;
            vmodel(p, ehs, evs, eact, h, v);
            checks++;
            if ({hsync, vsync, act_o} !== {ehs, evs, eact}) begin
                errors++; if (errors < 40) $display("FAIL mid_timing p=%0d got %b want %b", p, {hsync, vsync, act_o}, {ehs, evs, eact});
            end
            if (sof_pos < 0) begin
                checks++;
                if ({tready, level, locked} !== {1'b1, 7'd0, 1'b0}) begin
                    errors++; if (errors < 40) $display("FAIL mid_drop p=%0d got tready=%b level=%0d locked=%b want 1 0 0", p, tready, level, locked);
                end
            end
            if (locked && lockp < 0) begin
                lockp = p;
                checks++;
                if (sof_pos < 0 || p != (sof_pos / FT + 1) * FT) begin
                    errors++; $display("FAIL mid_lock_pos got %0d want %0d", p, (sof_pos / FT + 1) * FT);
                end
            end
            edat = (eact && locked) ? pix(v, h) : 8'd0;
            checks++;
            if (vdata !== edat) begin
                errors++; if (errors < 40) $display("FAIL mid_data p=%0d got %0d want %0d", p, vdata, edat);
            end
        end
        checks++;
        if (lockp < 0) begin errors++; $display("FAIL mid_nolock got none want lock"); end
    endtask

    task automatic test_stall;
        bit found = 1'b0, relocked = 1'b0, was_locked = 1'b1;
        int f0, n_uf = 0;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            @(negedge aclk);
            p = cyc - 1;
            if (locked && p % FT == 310) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL stall_wait got no locked line 5 want one"); end
        f0 = p - p % FT;
        src_on = 1'b0;
        for (int i = 0; i < 2 * FT; i++) begin
            if (i == 200) src_on = 1'b1;
            @(negedge aclk);
            p = cyc - 1;
            vmodel(p, ehs, evs, eact, h, v);
            checks++;
            if ({hsync, vsync, act_o} !== {ehs, evs, eact}) begin
                errors++; if (errors < 40) $display("FAIL stall_timing p=%0d got %b want %b", p, {hsync, vsync, act_o}, {ehs, evs, eact});
            end
            edat = (eact && locked) ? pix(v, h) : 8'd0;
            checks++;
            if (vdata !== edat) begin
                errors++; if (errors < 40) $display("FAIL stall_data p=%0d got %0d want %0d", p, vdata, edat);
            end
            if (underflow) begin
                n_uf++;
                checks++;
                if (locked !== 1'b0 || !eact || p >= f0 + FT) begin
                    errors++; $display("FAIL stall_uf_pulse p=%0d locked=%b act=%b", p, locked, eact);
                end
            end
            if (locked && !was_locked) begin
                relocked = 1'b1;
                checks++;
                if (p != f0 + FT) begin errors++; $display("FAIL stall_relock got %0d want %0d", p, f0 + FT); end
            end
            was_locked = locked;
        end
        checks++;
        if (n_uf != 1) begin errors++; $display("FAIL stall_uf_pulses got %0d want 1", n_uf); end
        checks++;
        if (ucount !== 16'd1) begin errors++; $display("FAIL stall_count got %0d want 1", ucount); end
        checks++;
        if (!relocked) begin errors++; $display("FAIL stall_norelock got none want %0d", f0 + FT); end
    endtask

    task automatic test_misalign;
        bit found = 1'b0, relocked = 1'b0, was_locked = 1'b1;
        int f0, n_se = 0;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            @(negedge aclk);
            p = cyc - 1;
            if (locked && p % FT == 100) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mis_wait got no locked frame want one"); end
        f0 = p - p % FT;
        src_bad_line = 10;
        for (int i = 0; i < 2 * FT; i++) begin
            @(negedge aclk);
            p = cyc - 1;
            vmodel(p, ehs, evs, eact, h, v);
            checks++;
            if ({hsync, vsync, act_o} !== {ehs, evs, eact}) begin
                errors++; if (errors < 40) $display("FAIL mis_timing p=%0d got %b want %b", p, {hsync, vsync, act_o}, {ehs, evs, eact});
            end
            edat = (eact && (locked || sync_err)) ? pix(v, h) : 8'd0;
            checks++;
            if (vdata !== edat) begin
                errors++; if (errors < 40) $display("FAIL mis_data p=%0d got %0d want %0d", p, vdata, edat);
            end
            if (sync_err) begin
                n_se++;
                src_bad_line = -1;
                checks++;
                if (p != f0 + 10 * 60 + 38 || locked !== 1'b0) begin
                    errors++; $display("FAIL mis_pulse got p=%0d locked=%b want p=%0d locked=0", p, locked, f0 + 638);
                end
            end
            if (locked && !was_locked) begin
                relocked = 1'b1;
                checks++;
                if (p != f0 + FT) begin errors++; $display("FAIL mis_relock got %0d want %0d", p, f0 + FT); end
            end
            was_locked = locked;
            checks++;
            if (underflow !== 1'b0) begin errors++; $display("FAIL mis_underflow p=%0d got 1 want 0", p); end
        end
        checks++;
        if (n_se != 1) begin errors++; $display("FAIL mis_pulses got %0d want 1", n_se); end
        checks++;
        if (!relocked) begin errors++; $display("FAIL mis_norelock got none want %0d", f0 + FT); end
    endtask

    task automatic test_enable;
        int lockp = -1;
        enable = 1'b0;
        for (int i = 0; i < 3 * FT; i++) begin
            @(negedge aclk);
            p = cyc - 1;
            vmodel(p, ehs, evs, eact, h, v);
            checks++;
            if ({hsync, vsync, act_o} !== {ehs, evs, eact}) begin
                errors++; if (errors < 40) $display("FAIL en_timing p=%0d got %b want %b", p, {hsync, vsync, act_o}, {ehs, evs, eact});
            end
            checks++;
            if ({tready, level, locked, underflow, vdata} !== '0) begin
                errors++; if (errors < 40) $display("FAIL en_hold p=%0d got tready=%b level=%0d locked=%b uf=%b data=%0d want 0", p, tready, level, locked, underflow, vdata);
            end
        end
        sof_pos = -1;
        enable  = 1'b1;
        for (int i = 0; i < 3 * FT && lockp < 0; i++) begin
            @(negedge aclk);
            p = cyc - 1;
            vmodel(p, ehs, evs, eact, h, v);
            edat = (eact && locked) ? pix(v, h) : 8'd0;
            checks++;
            if (vdata !== edat) begin
                errors++; if (errors < 40) $display("FAIL en_data p=%0d got %0d want %0d", p, vdata, edat);
            end
            if (locked) begin
                lockp = p;
                checks++;
                if (sof_pos < 0 || p != (sof_pos / FT + 1) * FT) begin
                    errors++; $display("FAIL en_lock_pos got %0d want %0d", p, (sof_pos / FT + 1) * FT);
                end
            end
        end
        checks++;
        if (lockp < 0) begin errors++; $display("FAIL en_nolock got none want lock"); end
    endtask

    task automatic test_async_reset;
        bit found = 1'b0;
        for (int i = 0; i < FT && !found; i++) begin
            @(negedge aclk);
            p = cyc - 1;
            vmodel(p, ehs, evs, eact, h, v);
            if (h == 20 && v < 30 && locked) found = 1'b1;
        end
        checks++;
        if (!found || act_o !== 1'b1) begin errors++; $display("FAIL arst_wait got act=%b want locked active line", act_o); end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({hsync, vsync, act_o, locked, underflow, sync_err} !== 6'b100000) begin
            errors++; $display("FAIL arst_ctrl got %b want 100000", {hsync, vsync, act_o, locked, underflow, sync_err});
        end
        checks++;
        if ({vdata, ucount, level} !== '0) begin
            errors++; $display("FAIL arst_vals got data=%0d count=%0d level=%0d want 0", vdata, ucount, level);
        end
        src_on = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            p = cyc - 1;
            vmodel(p, ehs, evs, eact, h, v);
            checks++;
            if ({hsync, vsync, act_o, vdata} !== {ehs, evs, eact, 8'd0}) begin
                errors++; if (errors < 40) $display("FAIL arst_restart p=%0d got %b %0d", p, {hsync, vsync, act_o}, vdata);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        test_reset;
        aresetn = 1'b1;
        test_ppc2;
        test_stream;
        test_midframe;
        test_stall;
        test_misalign;
        test_enable;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
